// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 MEM-stage data memory.
//   size_e  : access size encoding carried on i_size
//   state_e : data memory controller state
//   byte_en / store_lanes / misaligned : store lane and alignment helpers
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // behaves as a word access
    } size_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] byte_en(size_e sz, logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Right-justified store data replicated across lanes so that the
    // enabled lanes always see the right bytes.
    function automatic logic [3:0][7:0] store_lanes(size_e sz, logic [31:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(size_e sz, logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return |lane;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bus of the byte-enabled data memory.
//   master : pipeline side, drives i_* and samples o_*
//   slave  : memory side
interface data_memory_be_if;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_misalign;
    logic        o_range_err;

    modport master (
        output i_req, i_we, i_addr, i_data, i_size, i_unsigned,
        input  o_data, o_valid, o_busy, o_misalign, o_range_err
    );
    modport slave (
        input  i_req, i_we, i_addr, i_data, i_size, i_unsigned,
        output o_data, o_valid, o_busy, o_misalign, o_range_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of a
// 32-bit little-endian word and sign- or zero-extends it.
//   i_word     : raw memory word
//   i_lane     : byte address [1:0]
//   i_size     : access size (reserved encoding behaves as word)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   o_data     : extended result
module dmem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [31:0] shifted;
    logic [15:0] half_v;

    always_comb begin
        shifted = i_word >> {i_lane, 3'b000};
        half_v  = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (size_e'(i_size))
            SZ_BYTE: o_data = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: o_data = {{16{~i_unsigned & half_v[15]}}, half_v};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/data_memory_be.sv
// Byte-enabled MIPS32 data memory with registered, one-cycle-latency reads,
// misalignment / range flagging and a post-reset clear walk.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : request (i_*) and response (o_*) signals
// Pipeline: the request is accepted and the RAM read at edge N (stage 1),
// the aligned response is registered at edge N+1.
module data_memory_be
    import mips_mem_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int INIT_CLEAR = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    data_memory_be_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;

    logic [3:0][7:0] mem [DEPTH];
    logic [31:0]     rd_word_q;

    size_e          req_size;
    logic [AW-1:0]  req_idx;
    logic           req_mis, req_rng, busy, accept;

    logic           wr_en;
    logic [3:0]     wr_be;
    logic [AW-1:0]  wr_idx;
    logic [3:0][7:0] wr_data;

    // vld_pipe_q[0] = stage 1 (read issued), [1] = response visible
    logic [1:0]     vld_pipe_q, vld_pipe_d;
    logic           s1_zero_q, s1_zero_d, s1_mis_q, s1_mis_d, s1_rng_q, s1_rng_d;
    logic [1:0]     s1_lane_q, s1_lane_d, s1_size_q, s1_size_d;
    logic           s1_uns_q, s1_uns_d;
    logic [31:0]    ld_data, o_data_q, o_data_d;
    logic           o_mis_q, o_mis_d, o_rng_q, o_rng_d;

    assign req_size = size_e'(bus.i_size);
    assign req_idx  = bus.i_addr[AW+1:2];
    assign req_rng  = |bus.i_addr[31:AW+2];
    assign req_mis  = misaligned(req_size, bus.i_addr[1:0]);
    // Reset is synchronous, so busy must also see the raw reset input.
    assign busy     = !i_rst_n || (state_q == ST_INIT);
    assign accept   = bus.i_req && !busy;

    // Single RAM write port shared by the clear walk and stores.
    always_comb begin
        wr_en   = 1'b0;
        wr_be   = 4'h0;
        wr_idx  = req_idx;
        wr_data = store_lanes(req_size, bus.i_data);
        if (i_rst_n) begin
            if (state_q == ST_INIT) begin
                wr_en   = 1'b1;
                wr_be   = 4'hF;
                wr_idx  = cnt_q;
                wr_data = '0;
            end else if (accept && bus.i_we && !req_mis && !req_rng) begin
                wr_en = 1'b1;
                wr_be = byte_en(req_size, bus.i_addr[1:0]);
            end
        end
    end

    // Storage is not reset; read is synchronous so the array maps to RAM.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++)
            if (wr_en && wr_be[l]) mem[wr_idx][l] <= wr_data[l];
        if (accept) rd_word_q <= mem[req_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
        end
    end

    dmem_load_align u_align (
        .i_word     (rd_word_q),
        .i_lane     (s1_lane_q),
        .i_size     (s1_size_q),
        .i_unsigned (s1_uns_q),
        .o_data     (ld_data)
    );

    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], accept};
        s1_zero_d  = s1_zero_q;
        s1_mis_d   = s1_mis_q;
        s1_rng_d   = s1_rng_q;
        s1_lane_d  = s1_lane_q;
        s1_size_d  = s1_size_q;
        s1_uns_d   = s1_uns_q;
        if (accept) begin
            s1_zero_d = bus.i_we || req_mis || req_rng;
            s1_mis_d  = req_mis;
            s1_rng_d  = req_rng;
            s1_lane_d = bus.i_addr[1:0];
            s1_size_d = bus.i_size;
            s1_uns_d  = bus.i_unsigned;
        end
        o_data_d = o_data_q;
        if (vld_pipe_q[0]) o_data_d = s1_zero_q ? 32'h0 : ld_data;
        o_mis_d = vld_pipe_q[0] && s1_mis_q;
        o_rng_d = vld_pipe_q[0] && s1_rng_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            s1_zero_q  <= 1'b1;
            s1_mis_q   <= 1'b0;
            s1_rng_q   <= 1'b0;
            s1_lane_q  <= '0;
            s1_size_q  <= '0;
            s1_uns_q   <= 1'b0;
            o_data_q   <= '0;
            o_mis_q    <= 1'b0;
            o_rng_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            s1_zero_q  <= s1_zero_d;
            s1_mis_q   <= s1_mis_d;
            s1_rng_q   <= s1_rng_d;
            s1_lane_q  <= s1_lane_d;
            s1_size_q  <= s1_size_d;
            s1_uns_q   <= s1_uns_d;
            o_data_q   <= o_data_d;
            o_mis_q    <= o_mis_d;
            o_rng_q    <= o_rng_d;
        end
    end

    assign bus.o_data      = o_data_q;
    assign bus.o_valid     = vld_pipe_q[1];
    assign bus.o_busy      = busy;
    assign bus.o_misalign  = o_mis_q;
    assign bus.o_range_err = o_rng_q;
endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised byte-enabled data memory for the MIPS32 pipeline MEM stage, successor to the word-only data memory. Supports the full MIPS load/store size set (LB/LBU/LH/LHU/LW/SB/SH/SW) with sign or zero extension on loads. Reads are registered, with one-cycle latency and a valid strobe. Misalignment and out-of-range accesses are flagged instead of silently corrupting memory, and a post-reset clear sequence zeroes the array.

## Interface
- DEPTH, 128: number of 32-bit words; power of two, ≥ 4.
- INIT_CLEAR, 1: 1 = walk and zero the array after reset; 0 = skip clearing, ready immediately.
- i_clk  input  1  single clock, all logic on rising edge.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_req  input  1  access request, accepted when `i_req && !o_busy`.
- i_we  input  1  1 = store, 0 = load.
- i_addr  input  32  byte address; word index = `i_addr[31:2]`, lane = `i_addr[1:0]`.
- i_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- i_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- i_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- o_data  output  32  load result, valid with o_valid.
- o_valid  output  1  one-cycle pulse, one cycle after each accepted request (load or store).
- o_busy  output  1  high during reset and during the clear sequence.
- o_misalign  output  1  qualifies o_valid: the access was misaligned.
- o_range_err  output  1  qualifies o_valid: the word index was ≥ DEPTH.

## Operation
- States: INIT (clearing), READY.
- On reset go to INIT with clear counter = 0. If INIT_CLEAR=0, go to READY instead.
- INIT:
  - One word is zeroed per cycle at the counter address.
  - After word DEPTH-1 is cleared, go to READY.
  - o_busy = 1. i_req is ignored: no write, no o_valid.
- READY: o_busy = 0; each accepted request is processed.
- Byte lanes are little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- Store:
  - Byte: write `i_data[7:0]` into lane `addr[1:0]`.
  - Half: write `i_data[15:0]` into lanes {addr[1]*2+1, addr[1]*2}.
  - Word: write all four lanes.
  - Lanes not written keep their value.
- Load:
  - Extract the addressed byte or half and extend it per i_unsigned.
  - A word load ignores i_unsigned.
  - o_data = 0 on a store response.
- Alignment rules:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - On violation: no write, o_data = 0, o_misalign = 1 with o_valid.
- Range: if `i_addr[31:2] ≥ DEPTH`, then no write, o_data = 0, o_range_err = 1 with o_valid.
- Misalignment and range error can both be set on the same response.
- Memory contents are not reset, except by the INIT clear.

## Timing
- Reset values of registered outputs: o_data = 0, o_valid = 0, o_misalign = 0, o_range_err = 0.
- o_busy is 1 during reset. After reset release it stays 1 for exactly DEPTH cycles (INIT_CLEAR=1) or 0 cycles (INIT_CLEAR=0).
- Latency:
  - A request accepted at edge N gets its response outputs valid after edge N+1.
  - The store write commits at edge N.
- Back-to-back requests are accepted every cycle; no bubbles.
- A load the cycle after a store to the same word returns the newly written data.
- o_valid, o_misalign and o_range_err are single-cycle pulses, cleared in cycles with no accepted request.
- o_data holds its last value between responses.
- Reset asserted mid-operation:
  - Aborts the in-flight response (o_valid = 0 next cycle).
  - Restarts INIT from word 0.
  - A write requested in the same cycle as reset is dropped.

## Structure
- Shared package `mips_mem_pkg`:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - State encoding ST_INIT / ST_READY.
- Sub-module `dmem_load_align`:
  - Combinational.
  - Inputs: 32-bit word, lane, size, unsigned.
  - Output: extended 32-bit result.
  - Reused by the store-lane mux tests.
- Clear counter width is clog2(DEPTH).
- The storage array is inferred as a single 4-lane byte-writable RAM.

## Test plan
- Reset, then hold i_req = 1 → o_busy high for 128 cycles, with no o_valid and no write. A subsequent LW from 0x10 returns 0x00000000.
- SW 0x80FF7F01 @0x20, then LB @0x20, LB @0x21, LBU @0x21, LH @0x22, LHU @0x22 → responses 0x00000001, 0x0000007F, 0x0000007F, 0xFFFF80FF, 0x000080FF.
- SW 0x11223344 @0x0, then SB 0xAA @0x1, SH 0xBEEF @0x2, then LW @0x0 → 0xBEEFAA44.
- SH @0x3 and LW @0x2 → o_valid with o_misalign = 1 and o_data = 0; a later LW of the target word shows it unchanged.
- LW @0x200 (index 128, DEPTH = 128) → o_range_err = 1 and o_data = 0. SW @0x200 leaves word 0 unchanged (no aliasing).
- SW 0x12345678 @0x40, then reset asserted the next cycle for 1 cycle → o_valid = 0. The clear restarts, and after o_busy falls LW @0x40 = 0.
